// File: rtl/cache_define.sv
// Shared cache constants and the tree pseudo-LRU update used by the response
// stage and by the replacement victim select.
package cache_define;

    localparam int WAYS        = 4;
    localparam int WAY_W       = $clog2(WAYS);
    localparam int INDEX_W     = 6;
    localparam int OFFSET_W    = 3;
    localparam int CORE_DATA_W = 64;
    localparam int LINE_W      = CORE_DATA_W * (2 ** OFFSET_W);
    localparam int RSP_DEPTH   = 2;

    // Upper bounds so one function serves every associativity up to 64 ways.
    localparam int WAY_MAX_W   = 6;
    localparam int PLRU_MAX_W  = (1 << WAY_MAX_W) - 1;

    // Walk root->leaf along the accessed way (MSB first). A node is set to 1
    // when the access went left, so the victim pointer moves to the other half.
    function automatic logic [PLRU_MAX_W-1:0] plru_update(
        input logic [PLRU_MAX_W-1:0] plru,
        input logic [WAY_MAX_W-1:0]  way,
        input int                    way_w
    );
        logic [PLRU_MAX_W-1:0] res;
        logic                  right;
        int                    node;
        res  = plru;
        node = 0;
        for (int lvl = 0; lvl < WAY_MAX_W; lvl++) begin
            if (lvl < way_w) begin
                right     = way[way_w-1-lvl];
                res[node] = ~right;
                node      = 2 * node + 1 + int'(right);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_rsp_fifo.sv
// Small synchronous FIFO holding core responses; depth must be a power of 2.
module cache_rsp_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_response_nway.sv
// N-way cache response stage: returns the addressed (store-merged) word through
// a response FIFO and issues a one-cycle registered data/dirty/PLRU SRAM write.
module cache_response_nway #(
    parameter  int WAYS         = cache_define::WAYS,
    parameter  int INDEX_W      = cache_define::INDEX_W,
    parameter  int OFFSET_W     = cache_define::OFFSET_W,
    parameter  int CORE_DATA_W  = cache_define::CORE_DATA_W,
    parameter  int RSP_DEPTH    = cache_define::RSP_DEPTH,
    localparam int WAY_W        = $clog2(WAYS),
    localparam int PLRU_W       = WAYS - 1,
    localparam int WORDS        = 2 ** OFFSET_W,
    localparam int CORE_WSTRB_W = CORE_DATA_W / 8,
    localparam int LINE_W       = CORE_DATA_W * WORDS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [INDEX_W-1:0]      core_index,
    input  logic [OFFSET_W-1:0]     core_offset,
    input  logic                    core_wen,
    input  logic [CORE_WSTRB_W-1:0] core_wstrb,
    input  logic [CORE_DATA_W-1:0]  core_wdata,
    input  logic                    info_rsp,
    input  logic                    info_hit,
    input  logic [WAY_W-1:0]        info_hit_way,
    input  logic [LINE_W-1:0]       info_hit_data,
    input  logic [PLRU_W-1:0]       info_plru,
    input  logic                    rplc_rsp,
    input  logic [LINE_W-1:0]       rplc_rsp_data,
    input  logic [WAY_W-1:0]        info_rplc_way,
    output logic                    rsp_in_ready,
    output logic                    core_rsp_valid,
    input  logic                    core_rsp_ready,
    output logic [CORE_DATA_W-1:0]  core_rdata,
    output logic                    core_rsp_wen,
    output logic                    rsp_arb,
    output logic [WAYS-1:0]         rsp_data_cen,
    output logic [WAYS-1:0]         rsp_data_wen,
    output logic [INDEX_W-1:0]      rsp_data_addr,
    output logic [LINE_W-1:0]       rsp_data_wdata,
    output logic [LINE_W/8-1:0]     rsp_data_wstrb,
    output logic [WAYS-1:0]         rsp_dirty_wen,
    output logic [INDEX_W-1:0]      rsp_dirty_waddr,
    output logic                    rsp_lru_wen,
    output logic [INDEX_W-1:0]      rsp_lru_waddr,
    output logic [PLRU_W-1:0]       rsp_lru_wdata
);

    import cache_define::*;

    logic                   ev;
    logic                   accept;
    logic                   store_acc;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LINE_W-1:0]      line;
    logic [WAY_W-1:0]       way;
    logic [WAYS-1:0]        way_oh;
    logic [CORE_DATA_W-1:0] old_word;
    logic [CORE_DATA_W-1:0] rsp_word;
    logic [LINE_W/8-1:0]    line_wstrb;
    logic [CORE_DATA_W:0]   fifo_head;

    // Refill has priority; a coincident hit stays on its inputs until accepted.
    assign ev        = (info_rsp & info_hit) | rplc_rsp;
    assign accept    = ev & rsp_in_ready;
    assign store_acc = accept & core_wen;
    assign line      = rplc_rsp ? rplc_rsp_data : info_hit_data;
    assign way       = rplc_rsp ? info_rplc_way : info_hit_way;
    assign way_oh    = {{(WAYS-1){1'b0}}, 1'b1} << way;
    assign old_word  = line[core_offset*CORE_DATA_W +: CORE_DATA_W];

    always_comb begin
        rsp_word = old_word;
        if (core_wen) begin
            for (int b = 0; b < CORE_WSTRB_W; b++) begin
                if (core_wstrb[b]) rsp_word[8*b +: 8] = core_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        line_wstrb = '0;
        line_wstrb[core_offset*CORE_WSTRB_W +: CORE_WSTRB_W] = core_wstrb;
    end

    cache_rsp_fifo #(
        .WIDTH (CORE_DATA_W + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data ({rsp_word, core_wen}),
        .pop       (core_rsp_valid & core_rsp_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Ready follows the registered occupancy only; it is held low during reset.
    assign rsp_in_ready   = reset & ~fifo_full;
    assign core_rsp_valid = ~fifo_empty;
    assign core_rdata     = fifo_head[CORE_DATA_W:1];
    assign core_rsp_wen   = fifo_head[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_arb         <= 1'b0;
            rsp_data_cen    <= '0;
            rsp_data_wen    <= '0;
            rsp_data_addr   <= '0;
            rsp_data_wdata  <= '0;
            rsp_data_wstrb  <= '0;
            rsp_dirty_wen   <= '0;
            rsp_dirty_waddr <= '0;
            rsp_lru_wen     <= 1'b0;
            rsp_lru_waddr   <= '0;
            rsp_lru_wdata   <= '0;
        end else begin
            rsp_lru_wen   <= accept;
            rsp_arb       <= store_acc;
            rsp_data_cen  <= store_acc ? way_oh : '0;
            rsp_data_wen  <= store_acc ? way_oh : '0;
            rsp_dirty_wen <= store_acc ? way_oh : '0;
            if (accept) begin
                rsp_data_addr   <= core_index;
                rsp_dirty_waddr <= core_index;
                rsp_lru_waddr   <= core_index;
                rsp_data_wdata  <= {WORDS{core_wdata}};
                rsp_data_wstrb  <= core_wen ? line_wstrb : '0;
                rsp_lru_wdata   <= PLRU_W'(plru_update(PLRU_MAX_W'(info_plru),
                                                       WAY_MAX_W'(way), WAY_W));
            end
        end
    end

endmodule

// File: doc/cache_response_nway.md
Name: cache_response_nway

Overview:
Parametrised N-way successor to the 2-way cache response stage. It accepts a hit from the tag/info stage or a refill line from the replacement path, and returns the addressed word to the core over a valid/ready channel backed by a small response FIFO. The same accepted event drives a one-cycle-registered write into the data SRAM, the dirty-bit SRAM and the tree pseudo-LRU SRAM. Sits between cache_info/cache_replace and the core port.

Parameters:
WAYS, 4, associativity; power of 2, ≥2; WAY_W = clog2(WAYS)
INDEX_W, 6, set index width = SRAM address width
OFFSET_W, 3, word offset width; WORDS = 2**OFFSET_W
CORE_DATA_W, 64, core word width; CORE_WSTRB_W = CORE_DATA_W/8
LINE_W, CORE_DATA_W*WORDS, cache line width
RSP_DEPTH, 2, response FIFO depth (≥2, power of 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
core_index  in  INDEX_W  set of current request
core_offset  in  OFFSET_W  word within line
core_wen  in  1  request is a store
core_wstrb  in  CORE_WSTRB_W  store byte strobes
core_wdata  in  CORE_DATA_W  store data
info_rsp  in  1  info stage result valid
info_hit  in  1  lookup hit
info_hit_way  in  WAY_W  hit way
info_hit_data  in  LINE_W  hit line
info_plru  in  WAYS-1  current PLRU bits of set
rplc_rsp  in  1  refill line valid
rplc_rsp_data  in  LINE_W  refilled line
info_rplc_way  in  WAY_W  refill way
rsp_in_ready  out  1  block can accept an event
core_rsp_valid  out  1  response valid
core_rsp_ready  in  1  core accepts response
core_rdata  out  CORE_DATA_W  returned word
core_rsp_wen  out  1  response belongs to a store
rsp_arb  out  1  SRAM write port requested this cycle
rsp_data_cen / rsp_data_wen  out  WAYS  one-hot way enables
rsp_data_addr  out  INDEX_W  data SRAM address
rsp_data_wdata  out  LINE_W  line write data
rsp_data_wstrb  out  LINE_W/8  line byte strobes
rsp_dirty_wen  out  WAYS  dirty-bit set, one-hot
rsp_dirty_waddr  out  INDEX_W  dirty address
rsp_lru_wen  out  1  PLRU write
rsp_lru_waddr  out  INDEX_W  PLRU address
rsp_lru_wdata  out  WAYS-1  updated PLRU bits

Behaviour:
- Reset (reset=0, async): all outputs 0, FIFO empty, rsp_in_ready=1 after release; pending SRAM writes dropped.
- ev = (info_rsp & info_hit) | rplc_rsp. If both assert, refill wins; the hit is not consumed, and upstream holds it while rsp_in_ready was low. Accept = ev & rsp_in_ready.
- rsp_in_ready = FIFO count < RSP_DEPTH, registered-count based; no same-cycle pop bypass.
- line = refill ? rplc_rsp_data : info_hit_data; way = refill ? info_rplc_way : info_hit_way.
- Word = line[core_offset]. For a store, the returned word is merged: byte b = wstrb[b] ? wdata : old.
- On accept, push {word, core_wen} into FIFO. core_rsp_valid = !empty, and the head drives core_rdata/core_rsp_wen. Pop on valid&ready. Simultaneous push and pop at full is illegal by construction. Latency: accept → core_rsp_valid next cycle.
- SRAM writes are registered 1 cycle after accept, for one cycle only:
  - rsp_lru_wen=1, addr=core_index.
  - Store: rsp_arb=1. data cen=wen=onehot(way). wstrb is CORE_WSTRB_W ones at word core_offset, else 0. wdata is core_wdata replicated in all words. dirty_wen=onehot(way), addr=core_index.
  - Load: data/dirty enables 0, rsp_arb=0.
- PLRU: tree nodes with root 0; node n has children 2n+1 and 2n+2. Bit=1 means victim is in the right half. On access, walk root→leaf; set each node on the path to 1 if the access went left, 0 if right. Off-path bits copy info_plru.
- No SRAM write when ev is refused.

Decomposition:
- cache_define gains: WAYS, WAY_W, OFFSET_W, LINE_W, RSP_DEPTH and the PLRU-update function (pure combinational, shared with cache_replace's victim select).
- One sub-module: cache_rsp_fifo, a parametrised sync FIFO (width, depth) with count, async active-low reset, and push/pop/full/empty.

Test Plan:
1. Load hit: WAYS=4, hit way 2, offset 5, line word5=0x1122334455667788, plru=3'b000 → next cycle core_rsp_valid=1, rdata=0x1122334455667788, rsp_lru_wen=1, lru_wdata=3'b100, data/dirty enables 0.
2. Store hit: way 0, offset 1, wstrb=0x0F, wdata=0xAAAAAAAA_BBBBBBBB, old word 0xFFFF0000_12345678 → rdata=0xFFFF0000_BBBBBBBB, data_wen=4'b0001, wstrb bits[15:8]=0x0F with all others 0, dirty_wen=4'b0001, lru_wdata=3'b011, rsp_arb=1.
3. Simultaneous hit and refill (refill way 3, offset 0) → refill word returned, data_cen=4'b1000, hit not consumed.
4. Backpressure: core_rsp_ready=0, three hits offered → two accepted, rsp_in_ready=0 after the second, third held. Ready=1 → in-order drain, then the third is accepted.
5. Miss (info_rsp=1, info_hit=0) → no push, all write enables 0.
6. reset asserted with FIFO holding 2 entries and a write pending → outputs 0 asynchronously. After release, core_rsp_valid=0 and no stale SRAM write.
